priority_interrupt_controller_16: RTL
=====================================

# priority_interrupt_controller_16

Sixteen-source interrupt controller that captures request edges into a pending register, masks them and hands the highest-priority pending source to a CPU as a 4-bit vector. It uses a request/acknowledge/end-of-interrupt handshake. It sits directly upstream of the CPU interrupt port and wraps the 16:4 priority-encode function with the state that function lacks: latching, masking, holding and handshaking. Source 15 has the highest priority and source 0 the lowest.

## Interface
- NUM_SOURCES, 16, number of request lines; fixed at 16 for this release.
- VECTOR_WIDTH, 4, width of the vector; equals clog2(NUM_SOURCES).
- Clock_In  in  1  single clock; all logic is rising-edge.
- Reset_n_In  in  1  asynchronous, active-low reset.
- Enable_In  in  1  global enable; gates raising Irq_Out only, not capture.
- Request_In  in  16  raw request lines, synchronous to Clock_In; bit 15 has the highest priority.
- Mask_In  in  16  1 = source masked from selection; it is still captured into pending.
- Ack_In  in  1  CPU acknowledge; honoured only in REQUEST.
- Eoi_In  in  1  CPU end-of-interrupt; honoured only in SERVICE.
- Irq_Out  out  1  interrupt request to the CPU.
- Vector_Out  out  4  index of the offered or in-service source.
- In_Service_Out  out  1  high while an acknowledged interrupt is being serviced.
- Pending_Out  out  16  current pending register.

## Operation
- Edge capture: a register holds the previous value of Request_In; it resets to 0.
  - A rising edge on bit i sets pending[i].
  - A line held high through reset release therefore produces one edge on the first cycle.
- Selection: sel = highest i with pending[i] & ~Mask_In[i]. any = OR of (pending & ~Mask_In).
- FSM states: IDLE, REQUEST, SERVICE.
  - IDLE: if Enable_In & any, go to REQUEST and load Vector_Out with sel.
  - REQUEST: Irq_Out = 1.
    - Vector_Out re-tracks sel every cycle, so a higher-priority arrival pre-empts before Ack.
    - If any drops (the source was masked) or Enable_In drops, go to IDLE with Irq_Out = 0.
    - On Ack_In: clear pending[Vector_Out], go to SERVICE, freeze Vector_Out.
  - SERVICE: Irq_Out = 0, In_Service_Out = 1, no nesting. On Eoi_In, go to IDLE.
- Ack_In outside REQUEST and Eoi_In outside SERVICE are ignored.
- Simultaneous set and clear of the same pending bit (new edge coinciding with Ack): set wins, so the new event is kept.
- Enable_In low has no effect in SERVICE. Pending capture continues in every state.
- Reset (asynchronous, any state including mid-service): state IDLE, pending 0, previous-request register 0, Irq_Out 0, Vector_Out 0, In_Service_Out 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Edge sampled at clock edge k: pending set after edge k, Irq_Out high after edge k+1 (2-edge latency).
- Ack_In sampled at edge a: after edge a, Irq_Out = 0, In_Service_Out = 1 and the pending bit is clear.
- Eoi_In sampled at edge e: In_Service_Out = 0 after edge e. If another source is pending and unmasked, Irq_Out is high again after edge e+1.
- In REQUEST, Vector_Out and Irq_Out are updated together on the same edge.

## Structure
- Shared package holds:
  - constants NUM_SOURCES and VECTOR_WIDTH;
  - state encoding IDLE=2'd0, REQUEST=2'd1, SERVICE=2'd2.
- Sub-module irq_priority_select: combinational, taking 16-bit masked pending and producing a 4-bit index plus an any flag.
  - Index is 0 when nothing is pending; no high-impedance output.
- Top level holds the edge-capture, pending and FSM logic.

## Test plan
- Edge on source 5 at cycle 2, Enable_In = 1, no mask:
  - Irq_Out = 1 and Vector_Out = 5 at cycle 4.
  - Ack gives In_Service_Out = 1 and pending[5] = 0.
  - Eoi returns to IDLE with all outputs 0.
- Edges on 3 and 12 in the same cycle: vector 12 is offered first. After Ack and Eoi, vector 3 is offered 2 cycles after Eoi.
- Pre-emption: source 2 is offered; source 9 edge before Ack. Vector_Out changes to 9 while Irq_Out stays 1. Ack clears pending[9] only; pending[2] stays set.
- Mask: Mask_In[7] = 1 with an edge on 7. Pending_Out[7] = 1 and Irq_Out stays 0. Unmasking raises Irq_Out with vector 7 after one edge.
- Set-wins: a new edge on source 4 on the same cycle Ack services 4 leaves pending[4] = 1. Spurious Ack in IDLE and Eoi in REQUEST are ignored.
- Reset_n_In asserted mid-SERVICE with pending bits set: all outputs and pending go to 0 immediately (asynchronous). Request_In held high through reset release is re-captured as pending on the first edge after release.

Source files
------------

// File: rtl/priority_interrupt_controller_16_pkg.sv
// Shared constants and FSM state encoding for the 16-source interrupt controller.
`default_nettype none

package priority_interrupt_controller_16_pkg;

  localparam int NUM_SOURCES  = 16;
  localparam int VECTOR_WIDTH = $clog2(NUM_SOURCES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } pic_state_t;

endpackage

`default_nettype wire

// File: rtl/priority_interrupt_controller_16_irq_priority_select.sv
// Combinational 16:4 priority encoder; the highest set bit wins, index 0 when none set.
`default_nettype none

module irq_priority_select
  import priority_interrupt_controller_16_pkg::*;
(
  input  logic [NUM_SOURCES-1:0]  i_masked_pending,
  output logic [VECTOR_WIDTH-1:0] o_index,
  output logic                    o_any
);

  always_comb begin
    o_index = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (i_masked_pending[i]) begin
        o_index = VECTOR_WIDTH'(i);
      end
    end
  end

  assign o_any = |i_masked_pending;

endmodule

`default_nettype wire

// File: rtl/priority_interrupt_controller_16.sv
// Sixteen-source edge-captured interrupt controller with request/ack/EOI handshake.
`default_nettype none

module priority_interrupt_controller_16
  import priority_interrupt_controller_16_pkg::*;
(
  input  logic                    Clock_In,
  input  logic                    Reset_n_In,
  input  logic                    Enable_In,
  input  logic [NUM_SOURCES-1:0]  Request_In,
  input  logic [NUM_SOURCES-1:0]  Mask_In,
  input  logic                    Ack_In,
  input  logic                    Eoi_In,
  output logic                    Irq_Out,
  output logic [VECTOR_WIDTH-1:0] Vector_Out,
  output logic                    In_Service_Out,
  output logic [NUM_SOURCES-1:0]  Pending_Out
);

  pic_state_t               r_state;
  logic [NUM_SOURCES-1:0]   r_req_prev;
  logic [NUM_SOURCES-1:0]   r_pending;
  logic                     r_irq;
  logic [VECTOR_WIDTH-1:0]  r_vector;
  logic                     r_in_service;

  pic_state_t               w_state_nxt;
  logic                     w_irq_nxt;
  logic [VECTOR_WIDTH-1:0]  w_vector_nxt;
  logic                     w_in_service_nxt;
  logic [NUM_SOURCES-1:0]   w_clr;
  logic [NUM_SOURCES-1:0]   w_edge;
  logic [NUM_SOURCES-1:0]   w_pending_nxt;
  logic [NUM_SOURCES-1:0]   w_masked;
  logic [VECTOR_WIDTH-1:0]  w_sel;
  logic                     w_any;

  assign w_edge        = Request_In & ~r_req_prev;
  assign w_masked      = r_pending & ~Mask_In;
  // Set is applied after clear so a new edge on the acknowledged source is kept.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;

  irq_priority_select u_select (
    .i_masked_pending (w_masked),
    .o_index          (w_sel),
    .o_any            (w_any)
  );

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_state      <= IDLE;
      r_req_prev   <= '0;
      r_pending    <= '0;
      r_irq        <= 1'b0;
      r_vector     <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_prev   <= Request_In;
      r_pending    <= w_pending_nxt;
      r_irq        <= w_irq_nxt;
      r_vector     <= w_vector_nxt;
      r_in_service <= w_in_service_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_irq_nxt        = r_irq;
    w_vector_nxt     = r_vector;
    w_in_service_nxt = r_in_service;
    w_clr            = '0;
    case (r_state)
      IDLE: begin
        if (Enable_In && w_any) begin
          w_state_nxt  = REQUEST;
          w_irq_nxt    = 1'b1;
          w_vector_nxt = w_sel;
        end
      end
      REQUEST: begin
        // Ack takes precedence: the CPU acknowledged the vector it was shown.
        if (Ack_In) begin
          w_clr            = NUM_SOURCES'(1) << r_vector;
          w_state_nxt      = SERVICE;
          w_irq_nxt        = 1'b0;
          w_in_service_nxt = 1'b1;
        end else if (!Enable_In || !w_any) begin
          w_state_nxt  = IDLE;
          w_irq_nxt    = 1'b0;
          w_vector_nxt = '0;
        end else begin
          w_vector_nxt = w_sel;
        end
      end
      SERVICE: begin
        if (Eoi_In) begin
          w_state_nxt      = IDLE;
          w_in_service_nxt = 1'b0;
          w_vector_nxt     = '0;
        end
      end
      default: begin
        w_state_nxt      = IDLE;
        w_irq_nxt        = 1'b0;
        w_vector_nxt     = '0;
        w_in_service_nxt = 1'b0;
      end
    endcase
  end

  assign Irq_Out        = r_irq;
  assign Vector_Out     = r_vector;
  assign In_Service_Out = r_in_service;
  assign Pending_Out    = r_pending;

endmodule

`default_nettype wire
